// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// bubble instruction, PC increment and a word-alignment helper.
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        IFS_FETCH = 2'd0,
        IFS_KILL  = 2'd1,
        IFS_HOLD  = 2'd2
    } ifs_state_e;

    localparam logic [31:0] NOP_INST = 32'd0;
    localparam logic [31:0] PC_INC   = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues req/ack fetches and presents
// an instruction or a NOP bubble to the IF/ID register every cycle.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        stall,
    input  logic        condition_met,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_pc_add4,
    output logic [31:0] IF_inst,
    output logic        IF_valid,
    output logic [31:0] pc
);

    ifs_state_e  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_redirPc;
    logic [31:0] r_bufInst;
    logic [31:0] r_bufPcAdd4;

    logic [31:0] w_pcAdd4;
    logic [31:0] w_target;
    logic        w_redirect;

    // A redirect only counts when the pipeline is not stalled; ID re-asserts it later.
    assign w_pcAdd4   = r_pc + PC_INC;
    assign w_target   = align_word(branch_target);
    assign w_redirect = condition_met && !stall;

    // The request depends only on state and clr, never on stall.
    assign imem_req  = !clr && (r_state != IFS_HOLD);
    assign imem_addr = r_pc;
    assign pc        = r_pc;

    always_comb begin
        IF_inst    = NOP_INST;
        IF_pc_add4 = 32'd0;
        IF_valid   = 1'b0;
        if (!clr) begin
            case (r_state)
                IFS_FETCH: begin
                    if (imem_ack && !stall && !condition_met) begin
                        IF_inst    = imem_rdata;
                        IF_pc_add4 = w_pcAdd4;
                        IF_valid   = 1'b1;
                    end
                end
                IFS_HOLD: begin
                    if (stall || !condition_met) begin
                        IF_inst    = r_bufInst;
                        IF_pc_add4 = r_bufPcAdd4;
                        IF_valid   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // KILL waits out an in-flight request whose data must be dropped, keeping
    // the address stable, then jumps to the most recent redirect target.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= IFS_FETCH;
            r_pc        <= align_word(RESET_PC);
            r_redirPc   <= 32'd0;
            r_bufInst   <= 32'd0;
            r_bufPcAdd4 <= 32'd0;
        end else begin
            case (r_state)
                IFS_FETCH: begin
                    if (imem_ack) begin
                        if (stall) begin
                            r_bufInst   <= imem_rdata;
                            r_bufPcAdd4 <= w_pcAdd4;
                            r_pc        <= w_pcAdd4;
                            r_state     <= IFS_HOLD;
                        end else if (condition_met) begin
                            r_pc <= w_target;
                        end else begin
                            r_pc <= w_pcAdd4;
                        end
                    end else if (w_redirect) begin
                        r_redirPc <= w_target;
                        r_state   <= IFS_KILL;
                    end
                end
                IFS_KILL: begin
                    if (w_redirect) begin
                        r_redirPc <= w_target;
                    end
                    if (imem_ack) begin
                        r_pc    <= w_redirect ? w_target : r_redirPc;
                        r_state <= IFS_FETCH;
                    end
                end
                IFS_HOLD: begin
                    if (!stall) begin
                        if (condition_met) begin
                            r_pc <= w_target;
                        end
                        r_state <= IFS_FETCH;
                    end
                end
                default: r_state <= IFS_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: table-driven cycle vectors plus
// hand sequences, with a scoreboard of instructions IF/ID should capture.
module tb_if_fetch_stage;

    typedef struct {
        logic        stall;
        logic        cond;
        logic [31:0] target;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expPcAdd4;
    } vec_t;

    typedef struct {
        logic [31:0] pcAdd4;
        logic [31:0] inst;
    } sb_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        stall;
    logic        condition_met;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] IF_pc_add4;
    logic [31:0] IF_inst;
    logic        IF_valid;
    logic [31:0] pc;

    int   nChecks = 0;
    int   nFails  = 0;
    int   memWait = 0;
    int   waitCnt = 0;
    sb_t  sbQueue[$];
    vec_t vecs[13];

    if_fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .clr(clr), .stall(stall), .condition_met(condition_met),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .IF_pc_add4(IF_pc_add4),
        .IF_inst(IF_inst), .IF_valid(IF_valid), .pc(pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memInst(input logic [31:0] addr);
        return addr ^ 32'h5A5A_A5A5;
    endfunction

    // Memory model: acks after memWait idle cycles of a held request.
    always_comb begin
        imem_ack   = imem_req && (waitCnt >= memWait);
        imem_rdata = memInst(imem_addr);
    end

    always_ff @(posedge clk) begin
        if (clr || !imem_req || imem_ack) waitCnt <= 0;
        else                              waitCnt <= waitCnt + 1;
    end

    function automatic vec_t mk(input logic s, input logic c, input logic [31:0] t,
                                input logic r, input logic [31:0] a,
                                input logic v, input logic [31:0] p);
        vec_t x;
        x.stall = s; x.cond = c; x.target = t; x.expReq = r;
        x.expAddr = a; x.expValid = v; x.expPcAdd4 = p;
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushExp(input logic [31:0] pcAdd4);
        sb_t e;
        e.pcAdd4 = pcAdd4;
        e.inst   = memInst(pcAdd4 - 32'd4);
        sbQueue.push_back(e);
    endtask

    // One cycle: apply inputs after the edge, then at the falling edge pop the
    // scoreboard for any instruction IF/ID would capture.
    task automatic applyStimulus(input logic c, input logic s, input logic b,
                                 input logic [31:0] t, input int w);
        sb_t e;
        @(posedge clk);
        #1;
        clr = c; stall = s; condition_met = b; branch_target = t; memWait = w;
        @(negedge clk);
        if (IF_valid && !stall) begin
            if (sbQueue.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL sb_unexpected: got pc_add4 %h expected no instruction", IF_pc_add4);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("sb_pc_add4", IF_pc_add4, e.pcAdd4);
                checkOutput("sb_inst", IF_inst, e.inst);
            end
        end
    endtask

    task automatic checkBubble(input string name);
        checkOutput({name, "_valid"}, {31'd0, IF_valid}, 32'd0);
        checkOutput({name, "_inst"}, IF_inst, 32'd0);
        checkOutput({name, "_pc_add4"}, IF_pc_add4, 32'd0);
    endtask

    initial begin
        clr = 1'b1; stall = 1'b0; condition_met = 1'b0; branch_target = 32'd0;

        vecs[0]  = mk(0, 0, 32'h0,   1, 32'h100, 1, 32'h104);
        vecs[1]  = mk(0, 0, 32'h0,   1, 32'h104, 1, 32'h108);
        vecs[2]  = mk(0, 0, 32'h0,   1, 32'h108, 1, 32'h10C);
        vecs[3]  = mk(1, 0, 32'h0,   1, 32'h10C, 0, 32'h0);
        vecs[4]  = mk(1, 1, 32'h300, 0, 32'h110, 1, 32'h110);
        vecs[5]  = mk(1, 0, 32'h0,   0, 32'h110, 1, 32'h110);
        vecs[6]  = mk(0, 0, 32'h0,   0, 32'h110, 1, 32'h110);
        vecs[7]  = mk(0, 0, 32'h0,   1, 32'h110, 1, 32'h114);
        vecs[8]  = mk(0, 1, 32'h200, 1, 32'h114, 0, 32'h0);
        vecs[9]  = mk(0, 0, 32'h0,   1, 32'h200, 1, 32'h204);
        vecs[10] = mk(1, 1, 32'h400, 1, 32'h204, 0, 32'h0);
        vecs[11] = mk(0, 1, 32'h402, 0, 32'h208, 0, 32'h0);
        vecs[12] = mk(0, 0, 32'h0,   1, 32'h400, 1, 32'h404);

        applyStimulus(1, 0, 0, 32'h0, 0);
        applyStimulus(1, 0, 0, 32'h0, 0);
        checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
        checkBubble("rst");

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].expValid && !vecs[i].stall) pushExp(vecs[i].expPcAdd4);
            applyStimulus(0, vecs[i].stall, vecs[i].cond, vecs[i].target, 0);
            if (i == 0) checkOutput("rst_pc", pc, 32'h100);
            checkOutput($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].expReq});
            checkOutput($sformatf("vec%0d_addr", i), imem_addr, vecs[i].expAddr);
            checkOutput($sformatf("vec%0d_valid", i), {31'd0, IF_valid}, {31'd0, vecs[i].expValid});
            checkOutput($sformatf("vec%0d_pc_add4", i), IF_pc_add4, vecs[i].expPcAdd4);
            if (!vecs[i].expValid) checkOutput($sformatf("vec%0d_inst", i), IF_inst, 32'd0);
        end

        // Two-cycle memory: one bubble per instruction, address held during the wait.
        for (int k = 0; k < 4; k++) begin
            logic [31:0] a;
            a = 32'h404 + 32'(4 * (k / 2));
            if (k % 2 == 1) pushExp(a + 32'd4);
            applyStimulus(0, 0, 0, 32'h0, 1);
            checkOutput("lat2_addr", imem_addr, a);
            checkOutput("lat2_valid", {31'd0, IF_valid}, 32'(k % 2));
            if (k % 2 == 0) checkBubble("lat2");
        end

        // Redirect to 0x200 while a 3-cycle fetch at 0x40 is outstanding.
        applyStimulus(0, 0, 1, 32'h40, 0);
        checkBubble("jmp40");
        applyStimulus(0, 0, 0, 32'h0, 2);
        checkOutput("kill_addr0", imem_addr, 32'h40);
        applyStimulus(0, 0, 1, 32'h200, 2);
        checkBubble("kill_redir");
        applyStimulus(0, 0, 0, 32'h0, 2);
        checkOutput("kill_req", {31'd0, imem_req}, 32'd1);
        checkOutput("kill_addr2", imem_addr, 32'h40);
        checkBubble("kill_ack");
        applyStimulus(0, 0, 0, 32'h0, 2);
        checkOutput("kill_newaddr", imem_addr, 32'h200);
        applyStimulus(0, 0, 0, 32'h0, 2);
        pushExp(32'h204);
        applyStimulus(0, 0, 0, 32'h0, 2);
        checkOutput("kill_valid", {31'd0, IF_valid}, 32'd1);

        // PC wrap-around at the top of the address space.
        applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0);
        pushExp(32'h0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        checkOutput("wrap_valid", {31'd0, IF_valid}, 32'd1);
        pushExp(32'h4);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("wrap_addr1", imem_addr, 32'h0);

        // clr in the middle of a long wait abandons the request.
        applyStimulus(0, 0, 0, 32'h0, 5);
        applyStimulus(0, 0, 0, 32'h0, 5);
        checkOutput("midclr_addr", imem_addr, 32'h4);
        checkBubble("midclr_wait");
        applyStimulus(1, 0, 0, 32'h0, 5);
        checkOutput("midclr_req", {31'd0, imem_req}, 32'd0);
        checkBubble("midclr_during");
        applyStimulus(0, 0, 0, 32'h0, 5);
        checkOutput("midclr_pc", pc, 32'h100);
        checkOutput("midclr_addr2", imem_addr, 32'h100);
        checkBubble("midclr_after");

        checkOutput("sb_empty", 32'(sbQueue.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
